// File: rtl/periph_arbiter_pkg.sv
// Shared definitions for the peripheral arbiter: packet geometry, RX FSM
// states and the packet address extractor.
package periph_arbiter_pkg;

  localparam int unsigned usb_packet_width     = 32;
  localparam int unsigned periph_address_width = 4;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_READ    = 2'd1,
    RX_CAPTURE = 2'd2,
    RX_PRESENT = 2'd3
  } rx_state_t;

  // The destination peripheral index lives in the top bits of every packet.
  function automatic logic [periph_address_width-1:0] get_packet_addr(
    input logic [usb_packet_width-1:0] pkt
  );
    return pkt[usb_packet_width-1 -: periph_address_width];
  endfunction

endpackage

// File: rtl/periph_arbiter_if.sv
// Packet bus between the USB FIFO side, the arbiter and the periph array.
// slave = arbiter side, master = USB/peripheral environment side.
interface periph_arbiter_if #(
  parameter int unsigned num_periphs = 4
);
  import periph_arbiter_pkg::*;

  logic [usb_packet_width-1:0]                   host_tx_data;
  logic                                          host_tx_valid;
  logic                                          host_tx_ready;
  logic [usb_packet_width-1:0]                   periph_tx_data;
  logic [num_periphs-1:0]                        periph_tx_valid;
  logic [num_periphs-1:0]                        periph_tx_full;
  logic [num_periphs-1:0][usb_packet_width-1:0]  periph_rx_data;
  logic [num_periphs-1:0]                        periph_rx_read;
  logic [num_periphs-1:0]                        periph_rx_empty;
  logic [num_periphs-1:0]                        periph_rx_almost_full;
  logic [usb_packet_width-1:0]                   host_rx_data;
  logic                                          host_rx_valid;
  logic                                          host_rx_ready;

  modport slave (
    input  host_tx_data, host_tx_valid, periph_tx_full,
    input  periph_rx_data, periph_rx_empty, periph_rx_almost_full,
    input  host_rx_ready,
    output host_tx_ready, periph_tx_data, periph_tx_valid,
    output periph_rx_read, host_rx_data, host_rx_valid
  );

  modport master (
    output host_tx_data, host_tx_valid, periph_tx_full,
    output periph_rx_data, periph_rx_empty, periph_rx_almost_full,
    output host_rx_ready,
    input  host_tx_ready, periph_tx_data, periph_tx_valid,
    input  periph_rx_read, host_rx_data, host_rx_valid
  );

endinterface

// File: rtl/periph_arbiter_rr_select.sv
// Rotating-priority first-one finder: returns the first set request at or
// after ptr, wrapping at n.
module rr_select #(
  parameter int unsigned n     = 4,
  parameter int unsigned idx_w = (n > 1) ? $clog2(n) : 1
) (
  input  logic [n-1:0]     req,
  input  logic [idx_w-1:0] ptr,
  output logic [idx_w-1:0] idx,
  output logic             found
);

  always_comb begin
    int unsigned      pos;
    logic [idx_w-1:0] pos_idx;
    idx     = '0;
    found   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned k = 0; k < n; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= n) pos = pos - n;
      pos_idx = idx_w'(pos);
      if (!found && req[pos_idx]) begin
        found = 1'b1;
        idx   = pos_idx;
      end
    end
  end

endmodule

// File: rtl/periph_arbiter.sv
// Routes host packets to peripheral TX FIFOs by address and drains peripheral
// RX FIFOs toward the host in round-robin bursts. Optional: ARB_ALMOST_FULL_PRIORITY_EN.
module periph_arbiter
  import periph_arbiter_pkg::*;
#(
  parameter int unsigned num_periphs = 4,
  parameter int unsigned burst_len   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  periph_arbiter_if.slave       bus,
  output logic [15:0]           tx_drop_count,
  output logic                  idle
);

  localparam int unsigned sel_w = (num_periphs > 1) ? $clog2(num_periphs) : 1;
  localparam int unsigned bc_w  = (burst_len > 1) ? $clog2(burst_len) : 1;

  // ---------------- TX routing ----------------
  logic [periph_address_width-1:0] tx_addr;
  logic [sel_w-1:0]                tx_idx;
  logic                            tx_addr_ok;

  always_comb begin
    tx_addr    = get_packet_addr(bus.host_tx_data);
    tx_idx     = sel_w'(tx_addr);
    tx_addr_ok = 32'(tx_addr) < num_periphs;
    bus.periph_tx_valid = '0;
    bus.host_tx_ready   = 1'b1;
    if (tx_addr_ok) begin
      bus.host_tx_ready           = ~bus.periph_tx_full[tx_idx];
      bus.periph_tx_valid[tx_idx] = bus.host_tx_valid & ~bus.periph_tx_full[tx_idx];
    end
  end

  assign bus.periph_tx_data = bus.host_tx_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_drop_count <= '0;
    end else if (bus.host_tx_valid && !tx_addr_ok && tx_drop_count != 16'hFFFF) begin
      tx_drop_count <= tx_drop_count + 16'd1;
    end
  end

  // ---------------- RX arbitration ----------------
  rx_state_t              state;
  logic [sel_w-1:0]       rr_ptr;
  logic [sel_w-1:0]       sel;
  logic [bc_w-1:0]        burst_cnt;
  logic [num_periphs-1:0] rx_pending;
  logic [sel_w-1:0]       norm_idx;
  logic                   norm_found;
  logic [sel_w-1:0]       grant_idx;
  logic                   grant_found;
  logic                   burst_more;

  assign rx_pending = ~bus.periph_rx_empty;

  rr_select #(.n(num_periphs), .idx_w(sel_w)) u_rr_norm (
    .req   (rx_pending),
    .ptr   (rr_ptr),
    .idx   (norm_idx),
    .found (norm_found)
  );

`ifdef ARB_ALMOST_FULL_PRIORITY_EN
  logic [num_periphs-1:0] af_req;
  logic [sel_w-1:0]       af_idx;
  logic                   af_found;
  logic                   prio_grant;

  assign af_req = rx_pending & bus.periph_rx_almost_full;

  rr_select #(.n(num_periphs), .idx_w(sel_w)) u_rr_af (
    .req   (af_req),
    .ptr   (rr_ptr),
    .idx   (af_idx),
    .found (af_found)
  );

  assign grant_found = af_found | norm_found;
  assign grant_idx   = af_found ? af_idx : norm_idx;
  // A pressure grant ignores burst_len and lasts while almost_full holds.
  assign burst_more  = rx_pending[sel] &
                       (prio_grant ? bus.periph_rx_almost_full[sel]
                                   : (32'(burst_cnt) < burst_len - 1));
`else
  assign grant_found = norm_found;
  assign grant_idx   = norm_idx;
  assign burst_more  = rx_pending[sel] & (32'(burst_cnt) < burst_len - 1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= RX_IDLE;
      rr_ptr             <= '0;
      sel                <= '0;
      burst_cnt          <= '0;
      bus.host_rx_valid  <= 1'b0;
      bus.host_rx_data   <= '0;
      bus.periph_rx_read <= '0;
`ifdef ARB_ALMOST_FULL_PRIORITY_EN
      prio_grant         <= 1'b0;
`endif
    end else begin
      unique case (state)
        RX_IDLE: begin
          if (grant_found) begin
            sel                <= grant_idx;
            burst_cnt          <= '0;
            bus.periph_rx_read <= num_periphs'(1) << grant_idx;
            state              <= RX_READ;
`ifdef ARB_ALMOST_FULL_PRIORITY_EN
            prio_grant         <= af_found;
`endif
          end
        end
        RX_READ: begin
          bus.periph_rx_read <= '0;
          state              <= RX_CAPTURE;
        end
        RX_CAPTURE: begin
          // FIFO head is valid one cycle after the read strobe.
          bus.host_rx_data  <= bus.periph_rx_data[sel];
          bus.host_rx_valid <= 1'b1;
          state             <= RX_PRESENT;
        end
        RX_PRESENT: begin
          if (bus.host_rx_ready) begin
            bus.host_rx_valid <= 1'b0;
            if (burst_more) begin
              burst_cnt          <= burst_cnt + 1'b1;
              bus.periph_rx_read <= num_periphs'(1) << sel;
              state              <= RX_READ;
            end else begin
              rr_ptr <= (32'(sel) == num_periphs - 1) ? '0 : sel + 1'b1;
              state  <= RX_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign idle = (state == RX_IDLE) & (&bus.periph_rx_empty) & ~bus.host_tx_valid;

endmodule

// File: tb/tb_periph_arbiter.sv
// Self-checking bench for periph_arbiter: directed TX/RX scenarios plus
// randomized RX bursts checked against a transaction-level arbitration model.
module tb_periph_arbiter;
  import periph_arbiter_pkg::*;

  localparam int unsigned NP = 3;
  localparam int unsigned BL = 4;
  localparam int unsigned W  = usb_packet_width;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] tx_drop_count;
  logic        idle;

  periph_arbiter_if #(.num_periphs(NP)) bus ();

  periph_arbiter #(.num_periphs(NP), .burst_len(BL)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .tx_drop_count (tx_drop_count),
    .idle          (idle)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Peripheral RX FIFO models: data appears on the cycle after a read strobe.
  logic [W-1:0]  fifo_q [NP][$];
  logic [W-1:0]  exp_q  [NP][$];
  logic [NP-1:0] empty_r = '1;
  logic [W-1:0]  pop_word;

  always @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (bus.periph_rx_read[i] && fifo_q[i].size() > 0) begin
        pop_word = fifo_q[i].pop_front();
        bus.periph_rx_data[i] <= pop_word;
      end
      empty_r[i] <= (fifo_q[i].size() == 0);
    end
  end
  assign bus.periph_rx_empty = empty_r;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic load(input int unsigned p, input int unsigned n);
    logic [W-1:0] d;
    logic [periph_address_width-1:0] pa;
    pa = periph_address_width'(p);
    for (int unsigned k = 0; k < n; k++) begin
      d = $urandom;
      d[W-1 -: periph_address_width] = pa;
      fifo_q[p].push_back(d);
      exp_q[p].push_back(d);
    end
  endtask

  // Arbitration reference: whole-burst decisions from packet counts alone.
  int unsigned exp_order[$];
  int unsigned model_rr = 0;

  function automatic void build_order(input logic [NP-1:0] af);
    int unsigned cnt[NP];
    int unsigned total, n, i;
    int          s;
    bit          prio;
    exp_order.delete();
    total = 0;
    for (int p = 0; p < NP; p++) begin
      cnt[p] = exp_q[p].size();
      total += cnt[p];
    end
    while (total > 0) begin
      s = -1;
      prio = 0;
`ifdef ARB_ALMOST_FULL_PRIORITY_EN
      for (int unsigned k = 0; k < NP; k++) begin
        i = (model_rr + k) % NP;
        if (s < 0 && af[i] && cnt[i] > 0) begin s = int'(i); prio = 1; end
      end
`endif
      for (int unsigned k = 0; k < NP; k++) begin
        i = (model_rr + k) % NP;
        if (s < 0 && cnt[i] > 0) s = int'(i);
      end
      n = 0;
      do begin
        exp_order.push_back(s);
        cnt[s]--;
        total--;
        n++;
      end while (cnt[s] > 0 && (prio ? af[s] : (n < BL)));
      model_rr = (s + 1) % NP;
    end
  endfunction

  task automatic drain(input string tag, input logic [NP-1:0] af, input int unsigned ready_pct);
    int unsigned  got, budget, p;
    logic         last_valid, last_ready;
    logic [W-1:0] last_data, expd;
    build_order(af);
    got = 0;
    budget = 20 * exp_order.size() + 40;
    last_valid = 1'b0;
    last_ready = 1'b0;
    last_data  = '0;
    while (got < exp_order.size() && budget > 0) begin
      @(negedge clk);
      bus.host_rx_ready = ($urandom_range(99) < ready_pct);
      #1;
      if (last_valid && !last_ready) begin
        chk({tag, "_hold_valid"}, bus.host_rx_valid, 1);
        chk({tag, "_hold_data"}, bus.host_rx_data, last_data);
      end
      if (bus.host_rx_valid) chk({tag, "_no_read"}, bus.periph_rx_read, 0);
      if (bus.host_rx_valid && bus.host_rx_ready) begin
        p = exp_order[got];
        expd = exp_q[p].pop_front();
        chk($sformatf("%s_pkt%0d_p%0d", tag, got, p), bus.host_rx_data, expd);
        got++;
      end
      last_valid = bus.host_rx_valid;
      last_ready = bus.host_rx_ready;
      last_data  = bus.host_rx_data;
      budget--;
    end
    chk({tag, "_count"}, got, exp_order.size());
    @(negedge clk);
    bus.host_rx_ready = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]  d, hold_d;
    logic [3:0]    a;
    logic          v;
    logic [NP-1:0] full, ev, af;
    logic          er;
    int unsigned   drops, exp_sat;
    bit            seen;

    bus.host_tx_data = '0;
    bus.host_tx_valid = 1'b0;
    bus.periph_tx_full = '0;
    bus.periph_rx_almost_full = '0;
    bus.host_rx_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rx_valid", bus.host_rx_valid, 0);
    chk("rst_rx_data", bus.host_rx_data, 0);
    chk("rst_rx_read", bus.periph_rx_read, 0);
    chk("rst_drop_count", tx_drop_count, 0);
    chk("rst_idle", idle, 1);
    rst = 1'b0;

    // TX directed: address 2
    @(negedge clk);
    d = 32'h2ABC_DEF0;
    bus.host_tx_data = d;
    bus.host_tx_valid = 1'b1;
    bus.periph_tx_full = '0;
    #1;
    chk("tx2_valid", bus.periph_tx_valid, 3'b100);
    chk("tx2_ready", bus.host_tx_ready, 1);
    chk("tx2_data", bus.periph_tx_data, d);
    chk("tx_busy_not_idle", idle, 0);
    bus.periph_tx_full = 3'b100;
    #1;
    chk("tx2_full_ready", bus.host_tx_ready, 0);
    chk("tx2_full_valid", bus.periph_tx_valid, 0);

    // TX randomized
    drops = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      d = $urandom;
      a = 4'($urandom_range(15));
      d[W-1 -: 4] = a;
      v = 1'($urandom_range(1));
      full = NP'($urandom_range(7));
      bus.host_tx_data = d;
      bus.host_tx_valid = v;
      bus.periph_tx_full = full;
      #1;
      ev = '0;
      er = 1'b1;
      if (a < NP) begin
        er = ~full[a];
        ev[a] = v & ~full[a];
      end
      chk("txr_valid", bus.periph_tx_valid, ev);
      chk("txr_ready", bus.host_tx_ready, er);
      chk("txr_data", bus.periph_tx_data, d);
      chk("txr_drops", tx_drop_count, drops);
      if (v && a >= NP) drops++;
    end

    // Bad-address flood: count must saturate
    bus.periph_tx_full = '0;
    bus.host_tx_valid = 1'b1;
    d = $urandom;
    d[W-1 -: 4] = 4'd3;
    bus.host_tx_data = d;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      #1;
      if (bus.periph_tx_valid != '0 || !bus.host_tx_ready) begin
        chk("flood_strobe", {bus.periph_tx_valid, bus.host_tx_ready}, {3'b000, 1'b1});
      end
    end
    chk("flood_ready", bus.host_tx_ready, 1);
    @(negedge clk);
    bus.host_tx_valid = 1'b0;
    #1;
    exp_sat = (drops + 70001 > 32'hFFFF) ? 32'hFFFF : drops + 70001;
    chk("flood_drop_sat", tx_drop_count, exp_sat);

    // Round-robin directed with first-packet latency
    rst = 1'b1;
    load(0, 6);
    load(2, 6);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_rr = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("lat_valid_c%0d", c), bus.host_rx_valid, (c == 3));
    end
    drain("rr", '0, 100);
    repeat (2) @(negedge clk);
    #1;
    chk("rr_idle", idle, 1);

    // Backpressure: hold ready low for 10 cycles
    load(1, 2);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (bus.host_rx_valid) seen = 1;
    end
    chk("bp_valid_seen", seen, 1);
    hold_d = bus.host_rx_data;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk("bp_valid", bus.host_rx_valid, 1);
      chk("bp_data", bus.host_rx_data, hold_d);
      chk("bp_read", bus.periph_rx_read, 0);
    end
    drain("bp", '0, 100);

    // Almost-full pressure scenario
    rst = 1'b1;
    af = 3'b100;
    bus.periph_rx_almost_full = af;
    load(2, 8);
    load(0, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_rr = 0;
    drain("prio", af, 100);

    // Randomized bursts with random backpressure
    for (int r = 0; r < 6; r++) begin
      repeat (2) @(negedge clk);
      #1;
      chk($sformatf("rnd%0d_idle", r), idle, 1);
      af = NP'($urandom_range(7));
      bus.periph_rx_almost_full = af;
      for (int p = 0; p < NP; p++) load(p, $urandom_range(8));
      drain($sformatf("rnd%0d", r), af, 30 + $urandom_range(70));
    end

    // Reset while a packet is presented
    bus.periph_rx_almost_full = '0;
    rst = 1'b1;
    load(0, 1);
    load(1, 3);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_rr = 0;
    bus.host_rx_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (bus.host_rx_valid) begin
        seen = 1;
        chk("rstp_first", bus.host_rx_data, exp_q[0].pop_front());
      end
    end
    chk("rstp_first_seen", seen, 1);
    @(negedge clk);
    bus.host_rx_ready = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (bus.host_rx_valid) seen = 1;
    end
    chk("rstp_second_seen", seen, 1);
    chk("rstp_second", bus.host_rx_data, exp_q[1].pop_front());
    rst = 1'b1;
    load(0, 1);
    @(negedge clk);
    #1;
    chk("rstp_valid_cleared", bus.host_rx_valid, 0);
    chk("rstp_read_cleared", bus.periph_rx_read, 0);
    @(negedge clk);
    rst = 1'b0;
    model_rr = 0;
    drain("rstp_resume", '0, 100);
    repeat (2) @(negedge clk);
    #1;
    chk("end_idle", idle, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
